router_pkt_ctrl: RTL and testbench

Upstream input stage of the 1x3 router, feeding the three per-port router FIFOs.
- Accepts a byte-serial packet from the source: header, then payload, then parity.
- Decodes the header address and drives write_en, lfd_state and data to the selected FIFO.
- Back-pressures the source with busy, computes running XOR parity and flags a mismatch.

---
 rtl/router_pkg.sv | 42 ++++
 rtl/router_pkt_ctrl_if.sv | 51 +++++
 rtl/router_parity_chk.sv | 65 ++++++
 rtl/router_pkt_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_router_pkt_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router input controller: bus widths, header field
// positions, the controller FSM state type and the address-to-port decoder.
// Header byte layout: {len[7:2], addr[1:0]}; addr 3 marks a packet to discard.
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int DATA_W  = 8;
  localparam int N_PORTS = 3;
  localparam int LEN_W   = 6;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE,
    LOAD_FIRST,
    LOAD_DATA,
    LOAD_PARITY,
    CHECK,
    DROP
  } state_e;

  // One-hot port select; the invalid address selects nothing, so write_en can
  // never strobe more than one FIFO and never strobes for a dropped packet.
  function automatic logic [N_PORTS-1:0] port_sel(input logic [1:0] addr);
    logic [N_PORTS-1:0] sel;
    case (addr)
      2'd0:    sel = 3'b001;
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_pkt_ctrl_if.sv
// -----------------------------------------------------------------------------
// router_pkt_ctrl_if
// Bundles the source handshake, the FIFO-side write bus and the status flags
// of the router input controller.
//   master modport : packet source / FIFO side (drives pkt_valid, data_in,
//                    fifo_full; observes everything else)
//   slave modport  : router_pkt_ctrl (consumes the source bytes and FIFO full
//                    flags; drives busy, write_en, lfd_state, data_out,
//                    parity_done, err, pkt_dropped)
// Optional macro ROUTER_PKT_ERR_CNT_EN adds err_cnt[7:0] to both modports.
// -----------------------------------------------------------------------------
interface router_pkt_ctrl_if;
  import router_pkg::*;

  logic                pkt_valid;
  logic [DATA_W-1:0]   data_in;
  logic [N_PORTS-1:0]  fifo_full;
  logic                busy;
  logic [N_PORTS-1:0]  write_en;
  logic                lfd_state;
  logic [DATA_W-1:0]   data_out;
  logic                parity_done;
  logic                err;
  logic                pkt_dropped;
`ifdef ROUTER_PKT_ERR_CNT_EN
  logic [7:0]          err_cnt;

  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, write_en, lfd_state, data_out, parity_done, err, pkt_dropped,
    input  err_cnt
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, write_en, lfd_state, data_out, parity_done, err, pkt_dropped,
    output err_cnt
  );
`else
  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, write_en, lfd_state, data_out, parity_done, err, pkt_dropped
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, write_en, lfd_state, data_out, parity_done, err, pkt_dropped
  );
`endif

endinterface

// File: rtl/router_parity_chk.sv
// -----------------------------------------------------------------------------
// router_parity_chk
// Running XOR parity of a packet (header plus payload) and comparison against
// the parity byte received at the end of the packet.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   init          : load the accumulator with data_in (header byte)
//   accumulate    : XOR data_in into the accumulator (payload byte)
//   latch         : capture data_in as the received parity byte
//   check         : update err from the comparison; mismatch pulses this cycle
//   data_in       : byte being accepted from the source
//   mismatch      : check && (received != calculated), single-cycle
//   err           : registered result of the most recent check
// -----------------------------------------------------------------------------
module router_parity_chk
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic              accumulate,
  input  logic              latch,
  input  logic              check,
  input  logic [DATA_W-1:0] data_in,
  output logic              mismatch,
  output logic              err
);

  logic [DATA_W-1:0] calc_par_q, calc_par_d;
  logic [DATA_W-1:0] rx_par_q,   rx_par_d;
  logic              err_q,      err_d;

  always_comb begin
    calc_par_d = calc_par_q;
    rx_par_d   = rx_par_q;
    err_d      = err_q;
    if (init) begin
      calc_par_d = data_in;
    end else if (accumulate) begin
      calc_par_d = calc_par_q ^ data_in;
    end
    if (latch) begin
      rx_par_d = data_in;
    end
    if (check) begin
      err_d = (rx_par_q != calc_par_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      calc_par_q <= '0;
      rx_par_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      calc_par_q <= calc_par_d;
      rx_par_q   <= rx_par_d;
      err_q      <= err_d;
    end
  end

  assign mismatch = check && (rx_par_q != calc_par_q);
  assign err      = err_q;

endmodule

// File: rtl/router_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// router_pkt_ctrl
// Upstream input stage of the 1x3 router. Accepts a byte-serial packet
// (header, payload, parity), steers it to one of three FIFOs with zero-latency
// pass-through, back-pressures the source with busy and checks XOR parity.
// Packets addressed to port 3 are consumed and discarded.
// Ports:
//   clock        : rising-edge system clock
//   reset        : synchronous active-high reset; forces all outputs to 0
//   bus (slave)  : pkt_valid, data_in, fifo_full in;
//                  busy, write_en, lfd_state, data_out, parity_done, err,
//                  pkt_dropped out
// Optional macro ROUTER_PKT_ERR_CNT_EN: adds bus.err_cnt, a saturating count
// of parity mismatches, cleared by reset.
// -----------------------------------------------------------------------------
module router_pkt_ctrl
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  router_pkt_ctrl_if.slave  bus
);

  state_e             state_q,   state_d;
  logic [DATA_W-1:0]  hdr_q,     hdr_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;

  logic [1:0]         addr_in;
  logic [LEN_W-1:0]   len_in;
  logic [1:0]         addr_cur;
  logic               full_in;
  logic               full_cur;
  logic               accept_cur;

  logic               busy_c;
  logic [N_PORTS-1:0] write_en_c;
  logic               lfd_state_c;
  logic [DATA_W-1:0]  data_out_c;
  logic               parity_done_c;
  logic               pkt_dropped_c;

  logic               par_init, par_acc, par_latch, par_check;
  logic               par_mismatch;
  logic               par_err;

  // Full flag of the FIFO selected by an address; the invalid address is
  // never considered full because dropped packets do not touch any FIFO.
  function automatic logic port_full(input logic [N_PORTS-1:0] full,
                                     input logic [1:0]         addr);
    return |(full & port_sel(addr));
  endfunction

  assign addr_in    = bus.data_in[ADDR_MSB:ADDR_LSB];
  assign len_in     = bus.data_in[LEN_MSB:LEN_LSB];
  assign addr_cur   = hdr_q[ADDR_MSB:ADDR_LSB];
  assign full_in    = port_full(bus.fifo_full, addr_in);
  assign full_cur   = port_full(bus.fifo_full, addr_cur);
  assign accept_cur = bus.pkt_valid && !full_cur;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DECODE;
      hdr_q     <= '0;
      len_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      len_cnt_q <= len_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    len_cnt_d     = len_cnt_q;
    busy_c        = 1'b0;
    write_en_c    = '0;
    lfd_state_c   = 1'b0;
    data_out_c    = '0;
    parity_done_c = 1'b0;
    pkt_dropped_c = 1'b0;
    par_init      = 1'b0;
    par_acc       = 1'b0;
    par_latch     = 1'b0;
    par_check     = 1'b0;

    case (state_q)
      DECODE: begin
        if (bus.pkt_valid) begin
          if (addr_in == ADDR_INVALID) begin
            // Header consumed; only the length is needed to skip the rest.
            len_cnt_d = len_in;
            state_d   = DROP;
          end else if (full_in) begin
            // Hold the header at the source until the target FIFO has room.
            busy_c = 1'b1;
          end else begin
            hdr_d     = bus.data_in;
            len_cnt_d = len_in;
            par_init  = 1'b1;
            state_d   = LOAD_FIRST;
          end
        end
      end

      LOAD_FIRST: begin
        // Header is written from the register one cycle after it was taken.
        busy_c      = 1'b1;
        write_en_c  = port_sel(addr_cur);
        lfd_state_c = 1'b1;
        data_out_c  = hdr_q;
        state_d     = (len_cnt_q != '0) ? LOAD_DATA : LOAD_PARITY;
      end

      LOAD_DATA: begin
        busy_c = full_cur;
        if (accept_cur) begin
          write_en_c = port_sel(addr_cur);
          data_out_c = bus.data_in;
          par_acc    = 1'b1;
          len_cnt_d  = len_cnt_q - 1'b1;
          if (len_cnt_q == LEN_W'(1)) begin
            state_d = LOAD_PARITY;
          end
        end
      end

      LOAD_PARITY: begin
        busy_c = full_cur;
        if (accept_cur) begin
          write_en_c = port_sel(addr_cur);
          data_out_c = bus.data_in;
          par_latch  = 1'b1;
          state_d    = CHECK;
        end
      end

      CHECK: begin
        busy_c        = 1'b1;
        par_check     = 1'b1;
        parity_done_c = 1'b1;
        state_d       = DECODE;
      end

      DROP: begin
        // len_cnt counts the remaining payload bytes; the byte seen at zero
        // is the parity byte, which ends the discarded packet.
        if (bus.pkt_valid) begin
          if (len_cnt_q == '0) begin
            pkt_dropped_c = 1'b1;
            state_d       = DECODE;
          end else begin
            len_cnt_d = len_cnt_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = DECODE;
      end
    endcase
  end

  router_parity_chk u_parity_chk (
    .clock      (clock),
    .reset      (reset),
    .init       (par_init),
    .accumulate (par_acc),
    .latch      (par_latch),
    .check      (par_check),
    .data_in    (bus.data_in),
    .mismatch   (par_mismatch),
    .err        (par_err)
  );

`ifdef ROUTER_PKT_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (par_mismatch) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = reset ? 8'h00 : err_cnt_q;
`else
  logic unused_mismatch;
  assign unused_mismatch = par_mismatch;
`endif

  // Outputs are combinational, so reset masks them to 0 in the same cycle.
  assign bus.busy        = reset ? 1'b0 : busy_c;
  assign bus.write_en    = reset ? '0   : write_en_c;
  assign bus.lfd_state   = reset ? 1'b0 : lfd_state_c;
  assign bus.data_out    = reset ? '0   : data_out_c;
  assign bus.parity_done = reset ? 1'b0 : parity_done_c;
  assign bus.pkt_dropped = reset ? 1'b0 : pkt_dropped_c;
  assign bus.err         = reset ? 1'b0 : par_err;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_ctrl
// Drives whole packets into router_pkt_ctrl and compares the FIFO-side writes,
// parity flags and drop pulses against a packet-level reference: a valid
// packet must appear byte-for-byte at FIFO[addr] with lfd_state on the header
// only, and err must equal (XOR of header and payload) != parity byte.
// -----------------------------------------------------------------------------
module tb_router_pkt_ctrl;
  import router_pkg::*;

  logic clock;
  logic reset;

  router_pkt_ctrl_if bus ();

  router_pkt_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors;
  int checks;

  // Reference state carried across packets.
  bit exp_err;
  int exp_err_cnt;

  // Observed FIFO writes and pulses, collected by the monitor.
  int obs_data[$];
  int obs_port[$];
  int obs_lfd[$];
  int pd_cnt;
  int drop_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.write_en != '0) begin
        int port;
        port = -1;
        chk("wr_onehot", int'($onehot(bus.write_en)), 1);
        for (int p = 0; p < N_PORTS; p++) begin
          if (bus.write_en[p]) port = p;
        end
        chk("wr_while_full",
            int'(((bus.fifo_full & bus.write_en) != '0) && !bus.lfd_state), 0);
        obs_data.push_back(int'(bus.data_out));
        obs_port.push_back(port);
        obs_lfd.push_back(int'(bus.lfd_state));
      end
      if (bus.parity_done) pd_cnt++;
      if (bus.pkt_dropped) drop_cnt++;
    end
  end

  // Sends one packet with header hdr and random payload.
  //   bad_par   : corrupt the parity byte (bit 0)
  //   stall_idx : byte index during which fifo_full[addr] is forced for
  //               stall_cyc cycles (busy must be high, no write)
  //   abort_idx : byte index at which reset is pulsed instead of sending
  //   rnd       : random idle cycles and random fifo_full
  task automatic run_pkt(input logic [7:0] hdr, input bit bad_par,
                         input int stall_idx, input int stall_cyc,
                         input int abort_idx, input bit rnd);
    logic [7:0] pkt[$];
    logic [7:0] par;
    logic [7:0] b;
    int  len, port, idx, cyc, stall_left;
    bit  held, is_drop, stalling, mism;

    len     = int'(hdr[7:2]);
    port    = int'(hdr[1:0]);
    is_drop = (port == 3);
    par     = hdr;
    pkt.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt.push_back(b);
      par ^= b;
    end
    mism = bad_par;
    if (bad_par) par ^= 8'h01;
    pkt.push_back(par);

    obs_data.delete();
    obs_port.delete();
    obs_lfd.delete();
    pd_cnt     = 0;
    drop_cnt   = 0;
    idx        = 0;
    cyc        = 0;
    held       = 0;
    stall_left = stall_cyc;

    while (idx < pkt.size()) begin
      if (cyc > 3000) begin
        chk("send_timeout", 1, 0);
        break;
      end
      cyc++;
      if (idx == abort_idx) begin
        reset         = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.data_in   = pkt[idx];
        @(negedge clock);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wr", int'(bus.write_en), 0);
        chk("rst_lfd", int'(bus.lfd_state), 0);
        chk("rst_dout", int'(bus.data_out), 0);
        chk("rst_pdone", int'(bus.parity_done), 0);
        chk("rst_drop", int'(bus.pkt_dropped), 0);
        @(posedge clock);
        #1;
        reset         = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.fifo_full = '0;
        exp_err       = 0;
        exp_err_cnt   = 0;
        @(negedge clock);
        chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_wr", int'(bus.write_en), 0);
        chk("post_rst_err", int'(bus.err), 0);
`ifdef ROUTER_PKT_ERR_CNT_EN
        chk("post_rst_err_cnt", int'(bus.err_cnt), 0);
`endif
        @(posedge clock);
        #1;
        return;
      end
      if (rnd && !held && ($urandom_range(0, 3) == 0)) begin
        bus.pkt_valid = 1'b0;
      end else begin
        bus.pkt_valid = 1'b1;
        bus.data_in   = pkt[idx];
      end
      bus.fifo_full = (rnd && ($urandom_range(0, 3) == 0)) ? 3'($urandom) : 3'b000;
      stalling = (idx == stall_idx) && (stall_left > 0);
      if (stalling) bus.fifo_full = 3'(1 << port);
      @(negedge clock);
      if (stalling) begin
        chk("stall_busy", int'(bus.busy), 1);
        chk("stall_no_wr", int'(bus.write_en), 0);
        stall_left--;
      end
      if (bus.pkt_valid && !bus.busy) begin
        idx++;
        held = 0;
      end else begin
        held = bus.pkt_valid;
      end
      @(posedge clock);
      #1;
    end

    bus.pkt_valid = 1'b0;
    bus.fifo_full = '0;

    if (is_drop) begin
      @(negedge clock);
      chk("drop_pulse", drop_cnt, 1);
      chk("drop_writes", obs_data.size(), 0);
      chk("drop_pdone", pd_cnt, 0);
      chk("drop_busy", int'(bus.busy), 0);
      @(posedge clock);
      #1;
    end else begin
      // Last byte was accepted at the previous edge: CHECK is now active.
      chk("pdone_now", int'(bus.parity_done), 1);
      @(posedge clock);
      #1;
      @(negedge clock);
      exp_err = mism;
      if (mism && exp_err_cnt < 255) exp_err_cnt++;
      chk("pdone_cnt", pd_cnt, 1);
      chk("err", int'(bus.err), int'(exp_err));
`ifdef ROUTER_PKT_ERR_CNT_EN
      chk("err_cnt", int'(bus.err_cnt), exp_err_cnt);
`endif
      chk("idle_busy", int'(bus.busy), 0);
      chk("n_writes", obs_data.size(), pkt.size());
      for (int i = 0; i < pkt.size() && i < obs_data.size(); i++) begin
        chk("wr_data", obs_data[i], int'(pkt[i]));
        chk("wr_port", obs_port[i], port);
        chk("wr_lfd", obs_lfd[i], (i == 0) ? 1 : 0);
      end
      chk("drop_none", drop_cnt, 0);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    exp_err       = 0;
    exp_err_cnt   = 0;
    pd_cnt        = 0;
    drop_cnt      = 0;
    reset         = 1'b1;
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h39;
    bus.fifo_full = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_wr", int'(bus.write_en), 0);
    chk("reset_lfd", int'(bus.lfd_state), 0);
    chk("reset_dout", int'(bus.data_out), 0);
    chk("reset_err", int'(bus.err), 0);
    chk("reset_pdone", int'(bus.parity_done), 0);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.pkt_valid = 1'b0;
    @(negedge clock);
    chk("idle_busy0", int'(bus.busy), 0);
    chk("idle_wr0", int'(bus.write_en), 0);
    @(posedge clock);
    #1;

    // Good packet, len 14 to port 1.
    run_pkt(8'h39, 0, -1, 0, -1, 0);
    // Same header with corrupted parity.
    run_pkt(8'h39, 1, -1, 0, -1, 0);
    // Reset during payload byte 7, then a clean packet.
    run_pkt(8'h39, 0, -1, 0, 7, 0);
    run_pkt(8'h39, 0, -1, 0, -1, 0);
    // FIFO 1 full for 3 cycles while payload byte 5 is presented.
    run_pkt(8'h39, 0, 5, 3, -1, 0);
    // Discarded packet: len 2, addr 3.
    run_pkt(8'h0B, 0, -1, 0, -1, 0);
    // Zero-length packet to port 2.
    run_pkt(8'h02, 0, -1, 0, -1, 0);
    // Header held while the target FIFO is full.
    run_pkt(8'h10, 1, 0, 4, -1, 0);

    for (int n = 0; n < 30; n++) begin
      run_pkt(8'($urandom), 1'($urandom_range(0, 1)), -1, 0, -1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
